// File: rtl/uart_rx_axis_fifo_if.sv
// AXI-Stream bundle carrying received UART words out of uart_rx_axis_fifo.
//   tdata  : received word, LSB = first data bit on the line
//   tuser  : [0] parity error, [1] framing error, [2] break
//   tvalid : word available
//   tready : consumer accept
interface uart_rx_axis_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tdata;
  logic [2:0]           tuser;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_axis_fifo.sv
// UART receiver with 3-sample majority vote, 5..9 data bits, optional
// parity, 1/2 stop bits, framing/break detection and a first-word-fall-
// through FIFO drained over AXI-Stream with full backpressure.
//   aclk, aresetn : clock, synchronous active-low reset
//   rx            : asynchronous serial line, idle high
//   m             : AXI-Stream master (tdata/tuser/tvalid/tready)
//   overrun       : one-cycle pulse when a completed word is dropped (FIFO full)
//   fifo_level    : number of words currently stored
module uart_rx_axis_fifo #(
  parameter int CLK_FREQ    = 100,
  parameter int BIT_RATE    = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             rx,
  uart_rx_axis_fifo_if.master              m,
  output logic                             overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int CPB = (CLK_FREQ * 1000000) / BIT_RATE;
  localparam int H   = CPB / 2;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  // ---------------- synchroniser and edge detect ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   fall;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sync_q  <= '0;
      rx_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev & ~rx_s;

  // ---------------- receiver FSM ----------------
  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_idx, bit_d;
  logic                 stop_idx, stop_d;
  logic [DATA_BITS-1:0] shreg, sh_d;
  logic                 perr, perr_d;
  logic                 ferr, ferr_d;
  logic                 par_bit, par_d;
  logic                 samp_a, samp_b;
  logic                 maj;
  logic                 at_h1, at_wrap;
  logic                 push;
  logic                 brk;
  logic [EW-1:0]        push_word;

  assign at_h1   = (cnt == CW'(H + 1));
  assign at_wrap = (cnt == CW'(CPB - 1));
  // Samples at H-1 and H are registered; the H+1 sample is the live line.
  assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      par_bit  <= 1'b0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      stop_idx <= stop_d;
      shreg    <= sh_d;
      perr     <= perr_d;
      ferr     <= ferr_d;
      par_bit  <= par_d;
      if (cnt == CW'(H - 1)) samp_a <= rx_s;
      if (cnt == CW'(H))     samp_b <= rx_s;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    stop_d    = stop_idx;
    sh_d      = shreg;
    perr_d    = perr;
    ferr_d    = ferr;
    par_d     = par_bit;
    push      = 1'b0;
    brk       = 1'b0;
    push_word = '0;

    if (state != IDLE && state != WAIT_HIGH)
      cnt_d = at_wrap ? '0 : cnt + CW'(1);

    case (state)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          par_d   = 1'b0;
        end
      end
      START: begin
        if (at_h1 && maj) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_h1) sh_d = {maj, shreg[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_idx + BW'(1);
          end
        end
      end
      PAR: begin
        if (at_h1) begin
          par_d  = maj;
          perr_d = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
        end
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        if (at_h1) begin
          if (!maj) ferr_d = 1'b1;
          // The word is committed mid-way through the last stop bit so the
          // receiver can resync on a start bit that follows early.
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            push      = 1'b1;
            brk       = (shreg == '0) && !par_bit && !maj;
            push_word = {brk, ferr_d, perr, shreg};
            state_d   = brk ? WAIT_HIGH : IDLE;
            cnt_d     = '0;
          end
        end else if (at_wrap) begin
          stop_d = stop_idx + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          full, empty, pop, push_ok;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop     = !empty && m.tready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge aclk) begin
    if (aresetn && push_ok) mem[wptr] <= push_word;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      overrun <= push && !push_ok;
    end
  end

  assign m.tvalid             = !empty;
  assign {m.tuser, m.tdata}   = empty ? '0 : mem[rptr];
  assign fifo_level           = level;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Directed bench for uart_rx_axis_fifo. Three instances:
//   dut0 : defaults (CPB=868), 8N1
//   dut1 : CPB=16, 7 data bits, even parity
//   dut2 : CPB=16, 8N1, FIFO_DEPTH=4
// A negedge monitor logs every accepted beat (and its cycle) per instance.
module tb_uart_rx_axis_fifo;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [2:0] rst_n;
  logic [2:0] rx_v;
  logic [2:0] ovr;
  logic [4:0] lvl0;
  logic [4:0] lvl1;
  logic [2:0] lvl2;

  uart_rx_axis_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_rx_axis_fifo_if #(.DATA_BITS(7)) if1 ();
  uart_rx_axis_fifo_if #(.DATA_BITS(8)) if2 ();

  uart_rx_axis_fifo dut0 (
    .aclk(aclk), .aresetn(rst_n[0]), .rx(rx_v[0]), .m(if0),
    .overrun(ovr[0]), .fifo_level(lvl0)
  );

  uart_rx_axis_fifo #(
    .CLK_FREQ(16), .BIT_RATE(1000000), .DATA_BITS(7), .PARITY(2)
  ) dut1 (
    .aclk(aclk), .aresetn(rst_n[1]), .rx(rx_v[1]), .m(if1),
    .overrun(ovr[1]), .fifo_level(lvl1)
  );

  uart_rx_axis_fifo #(
    .CLK_FREQ(16), .BIT_RATE(1000000), .FIFO_DEPTH(4)
  ) dut2 (
    .aclk(aclk), .aresetn(rst_n[2]), .rx(rx_v[2]), .m(if2),
    .overrun(ovr[2]), .fifo_level(lvl2)
  );

  // ---------------- monitor ----------------
  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [11:0] q0[$], q1[$], q2[$];
  int unsigned t0q[$], t2q[$];
  int unsigned ovr_cnt = 0;

  always @(negedge aclk) begin
    if (if0.tvalid && if0.tready) begin
      q0.push_back({if0.tuser, 1'b0, if0.tdata});
      t0q.push_back(cyc);
    end
    if (if1.tvalid && if1.tready) q1.push_back({if1.tuser, 2'b00, if1.tdata});
    if (if2.tvalid && if2.tready) begin
      q2.push_back({if2.tuser, 1'b0, if2.tdata});
      t2q.push_back(cyc);
    end
    if (ovr[2]) ovr_cnt = ovr_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives n bits LSB first, each for cpb cycles; starts and ends at posedge+1.
  task automatic send(input int idx, input int cpb, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_v[idx] = bits[i];
      repeat (cpb) @(posedge aclk);
      #1;
    end
  endtask

  task automatic idle(input int idx, input int cycles);
    rx_v[idx] = 1'b1;
    repeat (cycles) @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] frame8(input logic [7:0] d, input logic stop);
    return {22'd0, stop, d, 1'b0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  int unsigned r0 = 0, r1 = 0, r2 = 0;
  int unsigned t_start;
  int unsigned ovr_base;
  int unsigned base2;
  logic [11:0] b;
  int unsigned tp;

  initial begin
    rx_v       = '1;
    rst_n      = '0;
    if0.tready = 1'b1;
    if1.tready = 1'b1;
    if2.tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", if2.tvalid, 0);
    check("rst_tdata",  if2.tdata, 0);
    check("rst_tuser",  if2.tuser, 0);
    check("rst_level",  lvl2, 0);
    check("rst_overrun", ovr[2], 0);
    check("rst_tvalid0", if0.tvalid, 0);
    rst_n = '1;
    repeat (6) @(posedge aclk);
    #1;

    // ---- 0xA5 8N1 at CPB=868: beat expected 9*868+434+5 cycles after pin edge
    t_start = cyc;
    send(0, 868, frame8(8'hA5, 1'b1), 10);
    idle(0, 200);
    check("a5_count", q0.size(), 1);
    b  = (q0.size() > r0) ? q0[r0] : '1;
    tp = (t0q.size() > r0) ? t0q[r0] : 0;
    r0++;
    check("a5_data", b[7:0], 8'hA5);
    check("a5_user", b[11:9], 3'b000);
    check("a5_latency", tp - t_start, 8251);

    // ---- 7E1: 0x55 has four ones, so even parity bit is 0
    send(1, 16, {22'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10);
    idle(1, 32);
    send(1, 16, {22'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
    idle(1, 32);
    check("par_count", q1.size(), 2);
    b = (q1.size() > r1) ? q1[r1] : '1; r1++;
    check("par_ok_data", b[6:0], 7'h55);
    check("par_ok_user", b[11:9], 3'b000);
    b = (q1.size() > r1) ? q1[r1] : '1; r1++;
    check("par_bad_data", b[6:0], 7'h55);
    check("par_bad_user", b[11:9], 3'b001);

    // ---- dut2: glitch, framing error, break
    if2.tready = 1'b1;
    rx_v[2] = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    idle(2, 64);
    check("glitch_none", q2.size(), 0);

    send(2, 16, frame8(8'h3C, 1'b0), 10);
    idle(2, 48);
    check("ferr_count", q2.size() - r2, 1);
    b = (q2.size() > r2) ? q2[r2] : '1; r2++;
    check("ferr_data", b[7:0], 8'h3C);
    check("ferr_user", b[11:9], 3'b010);

    send(2, 16, 32'd0, 20);
    idle(2, 64);
    check("brk_count", q2.size() - r2, 1);
    b = (q2.size() > r2) ? q2[r2] : '1; r2++;
    check("brk_data", b[7:0], 8'h00);
    check("brk_user", b[11:9], 3'b110);

    // ---- overrun: 5 words into a 4-deep FIFO with no consumer
    if2.tready = 1'b0;
    ovr_base   = ovr_cnt;
    send(2, 16, frame8(8'h11, 1'b1), 10); idle(2, 16);
    send(2, 16, frame8(8'h22, 1'b1), 10); idle(2, 16);
    send(2, 16, frame8(8'h33, 1'b1), 10); idle(2, 16);
    send(2, 16, frame8(8'h44, 1'b1), 10); idle(2, 16);
    send(2, 16, frame8(8'h55, 1'b1), 10); idle(2, 32);
    check("ovr_level", lvl2, 4);
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    check("ovr_hold_valid", if2.tvalid, 1);
    check("ovr_hold_data", if2.tdata, 8'h11);
    base2      = r2;
    if2.tready = 1'b1;
    repeat (8) @(posedge aclk);
    #1;
    check("drain_count", q2.size() - base2, 4);
    for (int i = 0; i < 4; i++) begin
      b = (q2.size() > r2) ? q2[r2] : '1;
      check("drain_data", b[7:0], 8'h11 * (i + 1));
      check("drain_user", b[11:9], 3'b000);
      if (i > 0) begin
        tp = (t2q.size() > r2) ? t2q[r2] - t2q[r2-1] : 0;
        check("drain_gap", tp, 1);
      end
      r2++;
    end
    check("drain_level", lvl2, 0);
    check("drain_tvalid", if2.tvalid, 0);

    // ---- reset mid-DATA with two words stored
    if2.tready = 1'b0;
    send(2, 16, frame8(8'h5A, 1'b1), 10); idle(2, 16);
    send(2, 16, frame8(8'h66, 1'b1), 10); idle(2, 16);
    check("pre_rst_level", lvl2, 2);
    send(2, 16, 32'b1010, 4);
    rst_n[2] = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("mid_rst_tvalid", if2.tvalid, 0);
    check("mid_rst_tdata", if2.tdata, 0);
    check("mid_rst_tuser", if2.tuser, 0);
    check("mid_rst_level", lvl2, 0);
    check("mid_rst_overrun", ovr[2], 0);
    @(posedge aclk);
    #1;
    rst_n[2] = 1'b1;
    idle(2, 48);
    base2      = r2;
    if2.tready = 1'b1;
    send(2, 16, frame8(8'h81, 1'b1), 10);
    idle(2, 48);
    check("post_rst_count", q2.size() - base2, 1);
    b = (q2.size() > r2) ? q2[r2] : '1; r2++;
    check("post_rst_data", b[7:0], 8'h81);
    check("post_rst_user", b[11:9], 3'b000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
